// File: rtl/chol_div_seq.sv
// chol_div_seq: sequences one Cholesky column through an external pipelined
// divider (chol_div). Each element of the column is divided by the diagonal
// value L_jj. Quotients are returned in issue order with their element index.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   clken                    global clock enable; all state freezes when low
//   start, diag, n_elems     begin a column (divisor in 16.16, elements-1)
//   elem_valid/data/ready    dividend stream in
//   div_*                    connections to the external chol_div divider
//   q_valid/data/index       quotient stream out (one cycle after div_out)
//   busy, done, err          status
//
// Optional feature: define CHOL_DIV_ZERO_CHECK_EN to flag diag==0 at start
// (sticky err) and force every quotient of that column to 32'h7FFFFFFF.
module chol_div_seq #(
    parameter int DIV_LATENCY = 36,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clken,
    input  logic             start,
    input  logic [31:0]      diag,
    input  logic [IDX_W-1:0] n_elems,
    input  logic             elem_valid,
    input  logic [31:0]      elem_data,
    output logic             elem_ready,
    output logic             div_divisor_valid,
    output logic [31:0]      div_divisor,
    output logic             div_dividend_valid,
    output logic [31:0]      div_dividend,
    input  logic [31:0]      div_out,
    output logic             q_valid,
    output logic [31:0]      q_data,
    output logic [IDX_W-1:0] q_index,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   RET_ONE = {{IDX_W{1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [31:0]            diag_q, diag_d;
    logic [IDX_W-1:0]       n_q, n_d;
    logic [IDX_W-1:0]       issue_cnt_q, issue_cnt_d;
    logic [IDX_W:0]         ret_cnt_q, ret_cnt_d;
    logic [DIV_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [IDX_W-1:0]       idx_sr_q [DIV_LATENCY];
    logic [IDX_W-1:0]       idx_sr_d [DIV_LATENCY];
    logic                   q_valid_q, q_valid_d;
    logic [31:0]            q_data_q, q_data_d;
    logic [IDX_W-1:0]       q_index_q, q_index_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   hs_s;
    logic                   tail_s;

    // Ready is gated by clken so a source never sees a transfer that the
    // frozen state machine would not record.
    assign elem_ready         = (state_q == ISSUE) && clken;
    assign hs_s               = elem_valid && elem_ready;
    assign div_dividend_valid = hs_s;
    assign div_divisor_valid  = hs_s;
    assign div_dividend       = hs_s ? elem_data : 32'h0000_0000;
    assign div_divisor        = hs_s ? diag_q : 32'h0000_0000;
    assign tail_s             = vld_sr_q[DIV_LATENCY-1];

    assign q_valid = q_valid_q;
    assign q_data  = q_data_q;
    assign q_index = q_index_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

    // Next-state, counters, in-flight tracking and output staging.
    always_comb begin
        state_d     = state_q;
        diag_d      = diag_q;
        n_d         = n_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        err_d       = err_q;

        // Valid/index pipelines mirror the divider so the tail lines up with div_out.
        vld_sr_d[0] = hs_s;
        idx_sr_d[0] = issue_cnt_q;
        for (int i = 1; i < DIV_LATENCY; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
            idx_sr_d[i] = idx_sr_q[i-1];
        end

        if (hs_s) begin
            issue_cnt_d = issue_cnt_q + IDX_ONE;
        end else begin
            issue_cnt_d = issue_cnt_q;
        end

        // Results can return while still issuing when elem_valid has long gaps.
        if (tail_s) begin
            ret_cnt_d = ret_cnt_q + RET_ONE;
        end else begin
            ret_cnt_d = ret_cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    diag_d      = diag;
                    n_d         = n_elems;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
`ifdef CHOL_DIV_ZERO_CHECK_EN
                    err_d       = (diag == 32'h0000_0000);
`else
                    err_d       = 1'b0;
`endif
                    state_d     = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (hs_s && (issue_cnt_q == n_q)) begin
                    state_d = DRAIN;
                end else begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if (ret_cnt_q == ({1'b0, n_q} + RET_ONE)) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        q_valid_d = tail_s;
        if (tail_s) begin
            q_index_d = idx_sr_q[DIV_LATENCY-1];
`ifdef CHOL_DIV_ZERO_CHECK_EN
            q_data_d  = err_q ? 32'h7FFF_FFFF : div_out;
`else
            q_data_d  = div_out;
`endif
        end else begin
            q_index_d = '0;
            q_data_d  = 32'h0000_0000;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State register; everything advances only on clken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            diag_q      <= 32'h0000_0000;
            n_q         <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            vld_sr_q    <= '0;
            for (int i = 0; i < DIV_LATENCY; i++) begin
                idx_sr_q[i] <= '0;
            end
            q_valid_q   <= 1'b0;
            q_data_q    <= 32'h0000_0000;
            q_index_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (clken) begin
            state_q     <= state_d;
            diag_q      <= diag_d;
            n_q         <= n_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            vld_sr_q    <= vld_sr_d;
            for (int i = 0; i < DIV_LATENCY; i++) begin
                idx_sr_q[i] <= idx_sr_d[i];
            end
            q_valid_q   <= q_valid_d;
            q_data_q    <= q_data_d;
            q_index_q   <= q_index_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_chol_div_seq.sv
module tb_chol_div_seq;

    localparam int L = 36;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clken = 1'b1;
    logic        start = 1'b0;
    logic [31:0] diag = 32'h0;
    logic [3:0]  n_elems = 4'h0;
    logic        elem_valid = 1'b0;
    logic [31:0] elem_data = 32'h0;
    logic        elem_ready;
    logic        div_divisor_valid, div_dividend_valid;
    logic [31:0] div_divisor, div_dividend, div_out;
    logic        q_valid;
    logic [31:0] q_data;
    logic [3:0]  q_index;
    logic        busy, done, err;

    chol_div_seq #(.DIV_LATENCY(L), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .clken(clken), .start(start), .diag(diag),
        .n_elems(n_elems), .elem_valid(elem_valid), .elem_data(elem_data),
        .elem_ready(elem_ready), .div_divisor_valid(div_divisor_valid),
        .div_divisor(div_divisor), .div_dividend_valid(div_dividend_valid),
        .div_dividend(div_dividend), .div_out(div_out), .q_valid(q_valid),
        .q_data(q_data), .q_index(q_index), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int qv_total = 0;
    int done_cnt = 0;
    logic [31:0] cur_diag = 32'h0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  idx;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Divider stand-in: 16.16 quotient, L clken cycles after the input handshake;
    // division by zero saturates to all ones.
    function automatic logic [31:0] fx_div(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] num;
        logic [63:0] res;
        if (b == 32'h0) return 32'hFFFF_FFFF;
        num = {a, 16'h0000};
        res = num / {32'h0, b};
        return res[31:0];
    endfunction

    logic [31:0] pipe [L];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) pipe[i] <= 32'h0;
        end else if (clken) begin
            for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= div_dividend_valid ? fx_div(div_dividend, div_divisor) : 32'h0;
        end
    end
    assign div_out = pipe[L-1];

    // Monitor: pops the scoreboard on every q_valid and checks divider-port hygiene.
    always @(negedge clk) begin
        exp_t e;
        if (q_valid) begin
            qv_total++;
            if (sb.size() == 0) begin
                check("unexpected_q_valid", {63'h0, q_valid}, 64'h0);
            end else begin
                e = sb.pop_front();
                check("q_data", {32'h0, q_data}, {32'h0, e.data});
                check("q_index", {60'h0, q_index}, {60'h0, e.idx});
                check("q_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (div_dividend_valid || div_divisor_valid) begin
            check("div_valid_handshake",
                  {61'h0, div_dividend_valid, div_divisor_valid, elem_valid && elem_ready},
                  64'h7);
            check("div_divisor", {32'h0, div_divisor}, {32'h0, cur_diag});
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_col(input logic [31:0] d, input logic [3:0] n);
        start = 1'b1;
        diag = d;
        n_elems = n;
        cur_diag = d;
        tick();
        start = 1'b0;
    endtask

    // Present one element for one cycle; the handshake lands in this cycle.
    task automatic send(input logic [31:0] data, input logic [31:0] expq,
                        input logic [3:0] idx, input int shift, input bit push);
        exp_t e;
        check("elem_ready", {63'h0, elem_ready}, 64'h1);
        elem_valid = 1'b1;
        elem_data = data;
        if (push) begin
            e.data = expq;
            e.idx = idx;
            e.cyc = cyc + L + 1 + shift;
            sb.push_back(e);
        end
        tick();
        elem_valid = 1'b0;
    endtask

    task automatic wait_done(input int done_before);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 400 cycles");
        end
        @(negedge clk);
        check("done_one_cycle", {63'h0, done}, 64'h0);
        check("idle_after_done", {63'h0, busy}, 64'h0);
        check("done_count", 64'(done_cnt - done_before), 64'h1);
        check("scoreboard_empty", 64'(sb.size()), 64'h0);
        tick();
    endtask

    task automatic column_std(input int shift);
        send(32'h0001_0000, 32'h0000_8000, 4'd0, shift, 1'b1);
        send(32'h0004_0000, 32'h0002_0000, 4'd1, shift, 1'b1);
        send(32'h0006_0000, 32'h0003_0000, 4'd2, shift, 1'b1);
        send(32'h0008_0000, 32'h0004_0000, 4'd3, shift, 1'b1);
    endtask

    initial begin
        int d0;
        int qv0;
        // Reset state
        tick();
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_err", {63'h0, err}, 64'h0);
        check("rst_q_valid", {63'h0, q_valid}, 64'h0);
        check("rst_q_data", {32'h0, q_data}, 64'h0);
        check("rst_q_index", {60'h0, q_index}, 64'h0);
        check("rst_elem_ready", {63'h0, elem_ready}, 64'h0);
        check("rst_div_outs", {div_divisor, div_dividend}, 64'h0);
        tick();
        rst = 1'b0;
        tick();

        // Scenario 1: back-to-back column
        d0 = done_cnt;
        start_col(32'h0002_0000, 4'd3);
        check("s1_busy", {63'h0, busy}, 64'h1);
        check("s1_err", {63'h0, err}, 64'h0);
        column_std(0);
        check("s1_ready_drain", {63'h0, elem_ready}, 64'h0);
        wait_done(d0);

        // Scenario 2: gaps in elem_valid
        d0 = done_cnt;
        start_col(32'h0002_0000, 4'd3);
        send(32'h0001_0000, 32'h0000_8000, 4'd0, 0, 1'b1);
        tick();
        send(32'h0004_0000, 32'h0002_0000, 4'd1, 0, 1'b1);
        tick();
        send(32'h0006_0000, 32'h0003_0000, 4'd2, 0, 1'b1);
        tick();
        send(32'h0008_0000, 32'h0004_0000, 4'd3, 0, 1'b1);
        wait_done(d0);

        // Scenario 3: 10-cycle clken stall with operations in flight
        d0 = done_cnt;
        qv0 = qv_total;
        start_col(32'h0002_0000, 4'd3);
        column_std(10);
        repeat (5) tick();
        clken = 1'b0;
        repeat (10) tick();
        clken = 1'b1;
        check("s3_no_qv_early", 64'(qv_total - qv0), 64'h0);
        wait_done(d0);

        // Scenario 4: reset mid-column
        start_col(32'h0002_0000, 4'd3);
        send(32'h0001_0000, 32'h0, 4'd0, 0, 1'b0);
        send(32'h0004_0000, 32'h0, 4'd1, 0, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("s4_busy_rst", {63'h0, busy}, 64'h0);
        check("s4_ready_rst", {63'h0, elem_ready}, 64'h0);
        sb.delete();
        qv0 = qv_total;
        tick();
        rst = 1'b0;
        repeat (2 * L) tick();
        check("s4_no_qv_after_rst", 64'(qv_total - qv0), 64'h0);
        d0 = done_cnt;
        start_col(32'h0002_0000, 4'd3);
        column_std(0);
        wait_done(d0);

        // Scenario 5: zero divisor
        d0 = done_cnt;
        start_col(32'h0000_0000, 4'd1);
`ifdef CHOL_DIV_ZERO_CHECK_EN
        check("s5_err", {63'h0, err}, 64'h1);
        send(32'h0001_0000, 32'h7FFF_FFFF, 4'd0, 0, 1'b1);
        send(32'h0002_0000, 32'h7FFF_FFFF, 4'd1, 0, 1'b1);
`else
        check("s5_err", {63'h0, err}, 64'h0);
        send(32'h0001_0000, 32'hFFFF_FFFF, 4'd0, 0, 1'b1);
        send(32'h0002_0000, 32'hFFFF_FFFF, 4'd1, 0, 1'b1);
`endif
        wait_done(d0);

        // Scenario 6: start while busy is ignored
        d0 = done_cnt;
        start_col(32'h0002_0000, 4'd3);
        send(32'h0001_0000, 32'h0000_8000, 4'd0, 0, 1'b1);
        start = 1'b1;
        diag = 32'h0004_0000;
        n_elems = 4'd0;
        send(32'h0004_0000, 32'h0002_0000, 4'd1, 0, 1'b1);
        send(32'h0006_0000, 32'h0003_0000, 4'd2, 0, 1'b1);
        send(32'h0008_0000, 32'h0004_0000, 4'd3, 0, 1'b1);
        repeat (3) tick();
        check("s6_busy", {63'h0, busy}, 64'h1);
        start = 1'b0;
        wait_done(d0);

        check("final_sb_empty", 64'(sb.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chol_div_seq.md
CHOL_DIV_SEQ -- requirements
Module: chol_div_seq

Interface
REQ-001 SHALL have parameter DIV_LATENCY, default 36: clken-qualified cycles from the divider input handshake to a valid chol_div out, including the sub-const stage.
REQ-002 SHALL have parameter IDX_W, default 4: element index width; column length up to 2^IDX_W.
REQ-003 SHALL have port clk  in  1  the single clock.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port clken  in  1  global clock enable; also drives the divider's clken.
REQ-006 SHALL have port start  in  1  begin a column.
REQ-007 SHALL have port diag  in  32  divisor L_jj in 16.16 format, sampled on start.
REQ-008 SHALL have port n_elems  in  IDX_W  elements minus one, sampled on start.
REQ-009 SHALL have ports elem_valid (in, 1), elem_data (in, 32) and elem_ready (out, 1): the dividend stream.
REQ-010 SHALL have ports div_divisor_valid (out, 1), div_divisor (out, 32), div_dividend_valid (out, 1), div_dividend (out, 32) and div_out (in, 32): connections to chol_div.
REQ-011 SHALL have ports q_valid (out, 1), q_data (out, 32) and q_index (out, IDX_W): the quotient stream.
REQ-012 SHALL have ports busy (out, 1), done (out, 1) and err (out, 1).

Function
REQ-013 SHALL advance every register, counter and FSM only when clken=1; clken=0 freezes all state.
REQ-014 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-015 IDLE: start=1 latches diag and n_elems, clears issue_cnt and ret_cnt, and moves to ISSUE; start is ignored outside IDLE.
REQ-016 ISSUE: elem_ready=1; on elem_valid&&elem_ready, the block drives div_dividend=elem_data and div_divisor=latched diag, with both valids high for that one cycle, and increments issue_cnt.
REQ-017 ISSUE moves to DRAIN on the handshake where issue_cnt==n_elems.
REQ-018 SHALL track in-flight operations with a DIV_LATENCY-deep valid shift register and a parallel index shift register, both fed at the handshake.
REQ-019 When the tail bit is 1: q_valid=1, q_data=div_out and q_index=the tail index, all registered with one cycle of output latency.
REQ-020 DRAIN moves to DONE when ret_cnt reaches n_elems+1.
REQ-021 DONE: done=1 for exactly one clken cycle, then return to IDLE.
REQ-022 busy=1 in every state except IDLE.
REQ-023 Back-to-back elem_valid SHALL sustain one issue per cycle; gaps in elem_valid insert bubbles but do not reorder results.
REQ-024 n_elems=0 SHALL issue exactly one division.
REQ-025 Quotients SHALL leave in issue order, with q_index incrementing from 0 to n_elems.
REQ-026 div_divisor_valid and div_dividend_valid SHALL never be high outside a handshake.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE; clear all shift registers and counters; drive elem_ready, div_*_valid, q_valid, busy, done and err to 0; and zero q_data, q_index, div_divisor and div_dividend.
REQ-028 Reset mid-column SHALL discard all in-flight results, with no q_valid after rst deasserts.

Configuration
REQ-029 SHALL support macro CHOL_DIV_ZERO_CHECK_EN.
REQ-030 With CHOL_DIV_ZERO_CHECK_EN defined: diag==0 at start sets err=1, sticky until the next start or rst.
REQ-031 With CHOL_DIV_ZERO_CHECK_EN defined: while err=1, q_data is forced to 32'h7FFFFFFF; the index and timing of q_valid are unchanged.
REQ-032 Without CHOL_DIV_ZERO_CHECK_EN: err is tied to 0 and div_out passes through unmodified.

Verification
REQ-033 Scenario 1: diag=0x00020000, n_elems=3, dividends 0x00010000, 0x00040000, 0x00060000, 0x00080000, back-to-back.
- Required: q_valid for 4 consecutive cycles, starting DIV_LATENCY+1 cycles after the first handshake.
- Required: q_data 0x00008000, 0x00020000, 0x00030000, 0x00040000 with q_index 0..3.
- Required: done pulses once afterwards.
REQ-034 Scenario 2: same column, but elem_valid toggled 1,0,1,0.
- Required: q_valid pattern mirrors the gaps, shifted by DIV_LATENCY+1.
- Required: q_index stays in order 0..3.
REQ-035 Scenario 3: clken held 0 for 10 cycles while operations are in flight.
- Required: no q_valid during the stall.
- Required: results appear after resume, shifted by exactly 10 cycles.
REQ-036 Scenario 4: rst asserted 5 cycles after the second issue.
- Required: busy=0 immediately.
- Required: no q_valid for the following 2*DIV_LATENCY cycles.
- Required: a new start then completes normally.
REQ-037 Scenario 5 (macro defined): diag=0, n_elems=1.
- Required: err=1 after start.
- Required: two q_valid pulses, each with q_data=0x7FFFFFFF.
REQ-038 Scenario 6: start asserted while busy=1.
- Required: start is ignored.
- Required: the current column's outputs are unchanged.
